// File: rtl/reorder_buf.sv
// reorder_buf: in-order retirement buffer.
// Allocates robids at the tail, records out-of-order CDB completions and
// retires up to ROB_MAX_RETIRE consecutive done entries per cycle from the
// head onto a registered retire bus.
module reorder_buf #(
    parameter int ROB_SIZE        = 16,
    parameter int ROB_SIZE_CLOG   = 4,
    parameter int ISSUE_WIDTH_MAX = 2,
    parameter int ROB_MAX_RETIRE  = 2,
    parameter int CPU_NUM_LANES   = 3,
    parameter int SRC_LEN         = 5,
    parameter int DATA_LEN        = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [ISSUE_WIDTH_MAX-1:0]            instr_val_ar,
    input  logic [ISSUE_WIDTH_MAX*SRC_LEN-1:0]    rd_ar,
    input  logic [ISSUE_WIDTH_MAX-1:0]            rf_write_ar,
    output logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0] rob_is_ptr,
    output logic                                  rob_full,
    input  logic [CPU_NUM_LANES-1:0]              commit_instr_cdb,
    input  logic [CPU_NUM_LANES*ROB_SIZE_CLOG-1:0] robid_cdb,
    input  logic [CPU_NUM_LANES*DATA_LEN-1:0]     result_data_cdb,
    output logic [ROB_MAX_RETIRE-1:0]             val_ret,
    output logic [ROB_MAX_RETIRE*SRC_LEN-1:0]     rd_ret,
    output logic [ROB_MAX_RETIRE-1:0]             rfWrite_ret,
    output logic [ROB_MAX_RETIRE*DATA_LEN-1:0]    wb_data_ret,
    output logic [ROB_MAX_RETIRE*ROB_SIZE_CLOG-1:0] robid_ret
);

    localparam logic [ROB_SIZE_CLOG:0] FULL_LIMIT = (ROB_SIZE_CLOG+1)'(ROB_SIZE - ISSUE_WIDTH_MAX);

    // Entry storage
    logic [ROB_SIZE-1:0]      r_valid;
    logic [ROB_SIZE-1:0]      r_done;
    logic [ROB_SIZE-1:0]      r_rfw;
    logic [SRC_LEN-1:0]       r_rd   [ROB_SIZE];
    logic [DATA_LEN-1:0]      r_data [ROB_SIZE];
    logic [ROB_SIZE_CLOG-1:0] r_head;
    logic [ROB_SIZE_CLOG-1:0] r_tail;
    logic [ROB_SIZE_CLOG:0]   r_count;

    // Retire bus registers
    logic [ROB_MAX_RETIRE-1:0]               r_val_ret;
    logic [ROB_MAX_RETIRE*SRC_LEN-1:0]       r_rd_ret;
    logic [ROB_MAX_RETIRE-1:0]               r_rfw_ret;
    logic [ROB_MAX_RETIRE*DATA_LEN-1:0]      r_data_ret;
    logic [ROB_MAX_RETIRE*ROB_SIZE_CLOG-1:0] r_robid_ret;

    logic                                    w_full;
    logic [ROB_SIZE_CLOG:0]                  w_k;
    logic [ROB_SIZE_CLOG:0]                  w_r;
    logic                                    w_chain;
    logic [ROB_MAX_RETIRE-1:0]               w_sel;
    logic [ROB_SIZE_CLOG-1:0]                w_ret_idx [ROB_MAX_RETIRE];
    logic [ROB_MAX_RETIRE*SRC_LEN-1:0]       w_rd_nxt;
    logic [ROB_MAX_RETIRE-1:0]               w_rfw_nxt;
    logic [ROB_MAX_RETIRE*DATA_LEN-1:0]      w_data_nxt;
    logic [ROB_MAX_RETIRE*ROB_SIZE_CLOG-1:0] w_robid_nxt;

    assign w_full   = (r_count > FULL_LIMIT);
    assign rob_full = w_full;

    // Allocation count and robids offered to rename
    always_comb begin
        w_k        = '0;
        rob_is_ptr = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            w_k = w_k + (ROB_SIZE_CLOG+1)'(instr_val_ar[i]);
            rob_is_ptr[i*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] = r_tail + ROB_SIZE_CLOG'(i);
        end
        if (w_full) begin
            w_k = '0;
        end
    end

    // Strict in-order retire selection from the head, plus next retire-bus values
    always_comb begin
        w_chain     = 1'b1;
        w_sel       = '0;
        w_r         = '0;
        w_rd_nxt    = '0;
        w_rfw_nxt   = '0;
        w_data_nxt  = '0;
        w_robid_nxt = '0;
        for (int unsigned j = 0; j < ROB_MAX_RETIRE; j++) begin
            w_ret_idx[j] = r_head + ROB_SIZE_CLOG'(j);
            w_chain      = w_chain & r_valid[w_ret_idx[j]] & r_done[w_ret_idx[j]];
            w_sel[j]     = w_chain;
            w_r          = w_r + (ROB_SIZE_CLOG+1)'(w_chain);
            if (w_chain) begin
                w_rd_nxt[j*SRC_LEN +: SRC_LEN]                = r_rd[w_ret_idx[j]];
                w_rfw_nxt[j]                                  = r_rfw[w_ret_idx[j]];
                w_data_nxt[j*DATA_LEN +: DATA_LEN]            = r_data[w_ret_idx[j]];
                w_robid_nxt[j*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] = w_ret_idx[j];
            end
        end
    end

    // Entry state: writeback, then retire clear, then allocation (allocation wins)
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            for (int unsigned l = 0; l < CPU_NUM_LANES; l++) begin
                if (commit_instr_cdb[l] && r_valid[robid_cdb[l*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]]) begin
                    r_done[robid_cdb[l*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]] <= 1'b1;
                    r_data[robid_cdb[l*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]] <= result_data_cdb[l*DATA_LEN +: DATA_LEN];
                end
            end
            for (int unsigned j = 0; j < ROB_MAX_RETIRE; j++) begin
                if (w_sel[j]) begin
                    r_valid[w_ret_idx[j]] <= 1'b0;
                    r_done[w_ret_idx[j]]  <= 1'b0;
                end
            end
            for (int unsigned i = 0; i < ISSUE_WIDTH_MAX; i++) begin
                if (instr_val_ar[i] && !w_full) begin
                    r_valid[r_tail + ROB_SIZE_CLOG'(i)] <= 1'b1;
                    r_done[r_tail + ROB_SIZE_CLOG'(i)]  <= 1'b0;
                    r_rfw[r_tail + ROB_SIZE_CLOG'(i)]   <= rf_write_ar[i];
                    r_rd[r_tail + ROB_SIZE_CLOG'(i)]    <= rd_ar[i*SRC_LEN +: SRC_LEN];
                end
            end
            r_head  <= r_head + w_r[ROB_SIZE_CLOG-1:0];
            r_tail  <= r_tail + w_k[ROB_SIZE_CLOG-1:0];
            r_count <= r_count + w_k - w_r;
        end
    end

    // Retire bus register; reset/flush drops any pending retire
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_val_ret   <= '0;
            r_rd_ret    <= '0;
            r_rfw_ret   <= '0;
            r_data_ret  <= '0;
            r_robid_ret <= '0;
        end else begin
            r_val_ret   <= w_sel;
            r_rd_ret    <= w_rd_nxt;
            r_rfw_ret   <= w_rfw_nxt;
            r_data_ret  <= w_data_nxt;
            r_robid_ret <= w_robid_nxt;
        end
    end

    assign val_ret     = r_val_ret;
    assign rd_ret      = r_rd_ret;
    assign rfWrite_ret = r_rfw_ret;
    assign wb_data_ret = r_data_ret;
    assign robid_ret   = r_robid_ret;

endmodule
